// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder result path: bus widths, the
// accumulator FSM states and a helper that widens the adder bus.
package bk_pkg;

    localparam int unsigned BK_SUM_W  = 13;
    localparam int unsigned BK_DATA_W = 12;
    localparam int unsigned BK_WIDE_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } bk_state_e;

    // Zero-extend the adder bus (carry in the MSB) to the widest supported accumulator.
    function automatic logic [BK_WIDE_W-1:0] bk_widen(input logic [BK_SUM_W-1:0] sum);
        return BK_WIDE_W'(sum);
    endfunction

endpackage

// File: rtl/bk_sum_accumulator.sv
// Frame accumulator behind the 12-bit Brent-Kung adder: sums adder results over a
// programmable frame and presents total, beat count and sticky overflow on a valid/ready port.
module bk_sum_accumulator
    import bk_pkg::*;
#(
    parameter int unsigned SUM_W = BK_SUM_W,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             in_last,
    input  logic [CNT_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    bk_state_e        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [ACC_W-1:0] in_wide;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] first_len;
    logic [CNT_W-1:0] cnt_inc;

    assign accept    = in_valid & in_ready_q;
    assign in_wide   = ACC_W'(bk_widen(BK_SUM_W'(in_sum)));
    assign sum_ext   = {1'b0, acc_q} + {1'b0, in_wide};
    assign first_len = (frame_len == '0) ? CNT_W'(1) : frame_len;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Next-state and datapath update; every register holds unless a beat or handoff occurs.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = first_len;
                    acc_d   = in_wide;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last || first_len == CNT_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    cnt_d   = cnt_inc;
                    state_d = (in_last || cnt_inc == len_q) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bk_sum_accumulator.sv
// Directed bench for bk_sum_accumulator; a 14-bit accumulator copy shares the stimulus
// so the wrap case can be observed alongside the default 20-bit instance.
module tb_bk_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [12:0] in_sum;
    logic        in_last;
    logic [7:0]  frame_len;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [19:0] out_acc;
    logic [7:0]  out_count;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [13:0] s_out_acc;
    logic [7:0]  s_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bk_sum_accumulator #(.SUM_W(13), .ACC_W(20), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_last(in_last), .frame_len(frame_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    bk_sum_accumulator #(.SUM_W(13), .ACC_W(14), .CNT_W(8)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sum(in_sum), .in_last(in_last), .frame_len(frame_len),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
        .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and step until it is accepted; in_valid is left high.
    task automatic beat(input logic [12:0] sum, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_sum   = sum;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
    endtask

    task automatic handoff();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0;
        frame_len = 8'd0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count, out_ovf, in_ready} !== {1'b0, 20'd0, 8'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: valid=%0b acc=%0d cnt=%0d ovf=%0b rdy=%0b required 0/0/0/0/1",
                     out_valid, out_acc, out_count, out_ovf, in_ready);
        end
        frame_len = 8'd8;
        beat(13'd1, 1'b0); beat(13'd2, 1'b0); beat(13'd3, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (out_acc !== 20'd6 || out_count !== 8'd3) begin
            n_fail++;
            $display("FAIL reset_pre_accum: acc=%0d cnt=%0d required 6/3", out_acc, out_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count, in_ready} !== {1'b0, 20'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_frame: valid=%0b acc=%0d cnt=%0d rdy=%0b required 0/0/0/1",
                     out_valid, out_acc, out_count, in_ready);
        end
        frame_len = 8'd1;
        beat(13'd9, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b1, 20'd9, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_new_frame: valid=%0b acc=%0d cnt=%0d required 1/9/1",
                     out_valid, out_acc, out_count);
        end
        handoff();
    endtask

    task automatic test_basic_frame();
        frame_len = 8'd4;
        beat(13'd100, 1'b0); beat(13'd200, 1'b0); beat(13'd8191, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_not_done: out_valid=%0b required 0", out_valid);
        end
        beat(13'd1, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count, out_ovf, in_ready} !== {1'b1, 20'd8492, 8'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: valid=%0b acc=%0d cnt=%0d ovf=%0b rdy=%0b required 1/8492/4/0/0",
                     out_valid, out_acc, out_count, out_ovf, in_ready);
        end
        handoff();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 20'd8492) begin
            n_fail++;
            $display("FAIL basic_handoff: valid=%0b rdy=%0b acc=%0d required 0/1/8492",
                     out_valid, in_ready, out_acc);
        end
    endtask

    task automatic test_early_last();
        frame_len = 8'd10;
        beat(13'd5, 1'b0); beat(13'd7, 1'b1);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b1, 20'd12, 8'd2}) begin
            n_fail++;
            $display("FAIL early_last: valid=%0b acc=%0d cnt=%0d required 1/12/2",
                     out_valid, out_acc, out_count);
        end
        handoff();
    endtask

    task automatic test_overflow();
        frame_len = 8'd3;
        beat(13'd8191, 1'b0); beat(13'd8191, 1'b0); beat(13'd4, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({s_out_valid, s_out_acc, s_out_count, s_out_ovf} !== {1'b1, 14'd2, 8'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_wrap14: valid=%0b acc=%0d cnt=%0d ovf=%0b required 1/2/3/1",
                     s_out_valid, s_out_acc, s_out_count, s_out_ovf);
        end
        n_checks++;
        if (out_acc !== 20'd16386 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_nowrap20: acc=%0d ovf=%0b required 16386/0", out_acc, out_ovf);
        end
        handoff();
        frame_len = 8'd1;
        beat(13'd3, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({s_out_valid, s_out_acc, s_out_count, s_out_ovf} !== {1'b1, 14'd3, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_cleared: valid=%0b acc=%0d cnt=%0d ovf=%0b required 1/3/1/0",
                     s_out_valid, s_out_acc, s_out_count, s_out_ovf);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        frame_len = 8'd2;
        beat(13'd10, 1'b0); beat(13'd20, 1'b0);
        in_sum = 13'd77; in_last = 1'b0; frame_len = 8'd3; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({in_ready, out_valid, out_acc, out_count} !== {1'b0, 1'b1, 20'd30, 8'd2}) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, last rdy=%0b valid=%0b acc=%0d cnt=%0d required 0/1/30/2",
                     bad, in_ready, out_valid, out_acc, out_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_handoff: valid=%0b rdy=%0b cnt=%0d required 0/1/2", out_valid, in_ready, out_count);
        end
        tick();
        frame_len = 8'd1;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b0, 20'd77, 8'd1}) begin
            n_fail++;
            $display("FAIL bp_pending_beat1: valid=%0b acc=%0d cnt=%0d required 0/77/1",
                     out_valid, out_acc, out_count);
        end
        beat(13'd5, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== 8'd2) begin
            n_fail++;
            $display("FAIL len_not_resampled: valid=%0b cnt=%0d required 0/2", out_valid, out_count);
        end
        beat(13'd8, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b1, 20'd90, 8'd3}) begin
            n_fail++;
            $display("FAIL bp_frame_total: valid=%0b acc=%0d cnt=%0d required 1/90/3",
                     out_valid, out_acc, out_count);
        end
        handoff();
    endtask

    task automatic test_len0_gaps();
        frame_len = 8'd0;
        beat(13'd42, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b1, 20'd42, 8'd1}) begin
            n_fail++;
            $display("FAIL len0_one_beat: valid=%0b acc=%0d cnt=%0d required 1/42/1",
                     out_valid, out_acc, out_count);
        end
        handoff();
        frame_len = 8'd3;
        beat(13'd100, 1'b0);
        in_valid = 1'b0; in_sum = 13'd4000; in_last = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b0, 20'd100, 8'd1}) begin
            n_fail++;
            $display("FAIL gap_idle: valid=%0b acc=%0d cnt=%0d required 0/100/1",
                     out_valid, out_acc, out_count);
        end
        beat(13'd200, 1'b0);
        in_valid = 1'b0;
        tick(); tick();
        beat(13'd300, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_acc, out_count} !== {1'b1, 20'd600, 8'd3}) begin
            n_fail++;
            $display("FAIL gap_total: valid=%0b acc=%0d cnt=%0d required 1/600/3",
                     out_valid, out_acc, out_count);
        end
        handoff();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_early_last();
        test_overflow();
        test_backpressure();
        test_len0_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
